// File: rtl/dpmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dpmem_arbiter
// Purpose  : Shares a dual-port memory (one write port, one read port) between
//            two clients. Writes and reads are arbitrated independently with
//            separate round-robin pointers, so one write and one read may be
//            granted in the same cycle. Writes are fire-and-forget; a single
//            outstanding read is tracked through the memory valid/ready
//            handshake and its data is returned to the issuing client.
// Ports    : clk, rst            clock, asynchronous active-high reset
//            c_req/c_we          per-client request and type (1 = write)
//            c_addr/c_wdata      per-client address/data, client i at slice i
//            c_gnt               combinational grant (accept = c_req & c_gnt)
//            c_rvalid/c_rdata    read completion pulse and data
//            c_err               read timeout flag (with c_rvalid)
//            m_*                 registered memory strobes/address/data,
//                                m_rdata/m_ready returned from the memory
// Options  : DPMEM_ARB_TIMEOUT_EN  abandon a read after TIMEOUT wait cycles
// Revision : 1.0  initial release
// ============================================================================
module dpmem_arbiter #(
  parameter int MEM_WIDTH = 8,
  parameter int ADD_WIDTH = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               c_req,
  input  logic [1:0]               c_we,
  input  logic [2*ADD_WIDTH-1:0]   c_addr,
  input  logic [2*MEM_WIDTH-1:0]   c_wdata,
  output logic [1:0]               c_gnt,
  output logic [1:0]               c_rvalid,
  output logic [MEM_WIDTH-1:0]     c_rdata,
  output logic [1:0]               c_err,
  output logic                     m_valid,
  output logic                     m_wr_en,
  output logic [ADD_WIDTH-1:0]     m_wr_addr,
  output logic [MEM_WIDTH-1:0]     m_wr_data,
  output logic                     m_rd_en,
  output logic [ADD_WIDTH-1:0]     m_rd_addr,
  input  logic [MEM_WIDTH-1:0]     m_rdata,
  input  logic                     m_ready
);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_WAIT  = 2'd2
  } rd_state_t;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  rd_state_t state_q, state_d;
  logic                 wr_prio_q, wr_prio_d;
  logic                 rd_prio_q, rd_prio_d;
  logic                 rd_owner_q, rd_owner_d;
  logic [ADD_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                 m_wr_en_q, m_wr_en_d;
  logic [ADD_WIDTH-1:0] m_wr_addr_q, m_wr_addr_d;
  logic [MEM_WIDTH-1:0] m_wr_data_q, m_wr_data_d;
  logic                 m_rd_en_q, m_rd_en_d;
  logic [1:0]           c_rvalid_q, c_rvalid_d;
  logic [MEM_WIDTH-1:0] c_rdata_q, c_rdata_d;

  logic [1:0]           wr_cand, rd_cand;
  logic                 wr_win, rd_win;
  logic [ADD_WIDTH-1:0] wr_win_addr, rd_win_addr;
  logic [MEM_WIDTH-1:0] wr_win_data;
  logic                 wr_fire, rd_fire, raw_hit, rd_done;

`ifdef DPMEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]       c_err_q, c_err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Arbitration: a lone candidate wins, otherwise the priority pointer decides.
  always_comb begin
    wr_cand     = c_req & c_we;
    rd_cand     = c_req & ~c_we;
    wr_win      = (wr_cand == 2'b11) ? wr_prio_q : wr_cand[1];
    rd_win      = (rd_cand == 2'b11) ? rd_prio_q : rd_cand[1];
    wr_win_addr = wr_win ? c_addr[ADD_WIDTH +: ADD_WIDTH] : c_addr[0 +: ADD_WIDTH];
    wr_win_data = wr_win ? c_wdata[MEM_WIDTH +: MEM_WIDTH] : c_wdata[0 +: MEM_WIDTH];
    rd_win_addr = rd_win ? c_addr[ADD_WIDTH +: ADD_WIDTH] : c_addr[0 +: ADD_WIDTH];
    wr_fire     = ~rst & (wr_cand != 2'b00);
    // A read colliding with this cycle's write waits a cycle so the memory
    // performs the write first.
    raw_hit     = wr_fire & (wr_win_addr == rd_win_addr);
    rd_fire     = ~rst & (state_q == R_IDLE) & (rd_cand != 2'b00) & ~raw_hit;
    c_gnt       = (wr_fire ? onehot(wr_win) : 2'b00) | (rd_fire ? onehot(rd_win) : 2'b00);
  end

  // Next-state logic for the write pipeline stage and the read FSM.
  always_comb begin
    state_d     = state_q;
    wr_prio_d   = wr_prio_q;
    rd_prio_d   = rd_prio_q;
    rd_owner_d  = rd_owner_q;
    rd_addr_d   = rd_addr_q;
    m_wr_en_d   = wr_fire;
    m_wr_addr_d = m_wr_addr_q;
    m_wr_data_d = m_wr_data_q;
    m_rd_en_d   = 1'b0;
    c_rvalid_d  = 2'b00;
    c_rdata_d   = '0;
    rd_done     = 1'b0;
`ifdef DPMEM_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    c_err_d     = 2'b00;
`endif

    if (wr_fire) begin
      wr_prio_d   = ~wr_win;
      m_wr_addr_d = wr_win_addr;
      m_wr_data_d = wr_win_data;
    end

    case (state_q)
      R_IDLE: begin
        // m_ready is deliberately ignored here.
        if (rd_fire) begin
          rd_owner_d = rd_win;
          rd_addr_d  = rd_win_addr;
          rd_prio_d  = ~rd_win;
          m_rd_en_d  = 1'b1;
          state_d    = R_ISSUE;
        end
      end
      R_ISSUE: begin
        if (m_ready) begin
          rd_done = 1'b1;
        end else begin
          state_d = R_WAIT;
`ifdef DPMEM_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      R_WAIT: begin
        if (m_ready) begin
          rd_done = 1'b1;
        end
`ifdef DPMEM_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          // Last permitted wait cycle expired: complete with error, data 0.
          state_d    = R_IDLE;
          c_rvalid_d = onehot(rd_owner_q);
          c_err_d    = onehot(rd_owner_q);
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = R_IDLE;
    endcase

    if (rd_done) begin
      state_d    = R_IDLE;
      c_rvalid_d = onehot(rd_owner_q);
      c_rdata_d  = m_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= R_IDLE;
      wr_prio_q   <= 1'b0;
      rd_prio_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      rd_addr_q   <= '0;
      m_wr_en_q   <= 1'b0;
      m_wr_addr_q <= '0;
      m_wr_data_q <= '0;
      m_rd_en_q   <= 1'b0;
      c_rvalid_q  <= 2'b00;
      c_rdata_q   <= '0;
`ifdef DPMEM_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      c_err_q     <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      wr_prio_q   <= wr_prio_d;
      rd_prio_q   <= rd_prio_d;
      rd_owner_q  <= rd_owner_d;
      rd_addr_q   <= rd_addr_d;
      m_wr_en_q   <= m_wr_en_d;
      m_wr_addr_q <= m_wr_addr_d;
      m_wr_data_q <= m_wr_data_d;
      m_rd_en_q   <= m_rd_en_d;
      c_rvalid_q  <= c_rvalid_d;
      c_rdata_q   <= c_rdata_d;
`ifdef DPMEM_ARB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      c_err_q     <= c_err_d;
`endif
    end
  end

  assign m_wr_en   = m_wr_en_q;
  assign m_wr_addr = m_wr_addr_q;
  assign m_wr_data = m_wr_data_q;
  assign m_rd_en   = m_rd_en_q;
  assign m_rd_addr = rd_addr_q;
  assign m_valid   = m_wr_en_q | m_rd_en_q;
  assign c_rvalid  = c_rvalid_q;
  assign c_rdata   = c_rdata_q;
`ifdef DPMEM_ARB_TIMEOUT_EN
  assign c_err     = c_err_q;
`else
  assign c_err     = 2'b00;
`endif

endmodule
`default_nettype wire
